hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 91 +++++++++
 tb/tb_hazard_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based forwarding/load-use stall control for an in-order pipeline.
// Defining HAZARD_STATS_EN adds saturating stall_cnt/flush_cnt counters.
module hazard_ctrl #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 4,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [REG_AW-1:0]       src_a,
  input  logic [REG_AW-1:0]       src_b,
  input  logic                    use_a,
  input  logic                    use_b,
  input  logic [REG_AW-1:0]       dest,
  input  logic                    wreg,
  input  logic                    rmem,
  input  logic [DATA_W-1:0]       rf_a,
  input  logic [DATA_W-1:0]       rf_b,
  input  logic [DEPTH*DATA_W-1:0] stage_data,
  input  logic                    flush,
  output logic                    stall,
  output logic [DATA_W-1:0]       op_a,
  output logic [DATA_W-1:0]       op_b,
  output logic                    hit_a,
  output logic                    hit_b,
  output logic                    bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             flush_cnt
`endif
);
  logic [DEPTH-1:0]  v, w, m;
  logic [REG_AW-1:0] d [DEPTH];
  logic              blk_a, blk_b;
  // Scan oldest to youngest so the youngest match overrides, even when its data is not ready yet.
  always_comb begin
    op_a  = rf_a;
    op_b  = rf_b;
    hit_a = 1'b0;
    hit_b = 1'b0;
    blk_a = 1'b0;
    blk_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (use_a && v[k] && w[k] && d[k] == src_a) begin
        hit_a = ~m[k] || k >= LOAD_STAGE;
        blk_a = ~hit_a;
        op_a  = hit_a ? stage_data[k*DATA_W +: DATA_W] : rf_a;
      end
      if (use_b && v[k] && w[k] && d[k] == src_b) begin
        hit_b = ~m[k] || k >= LOAD_STAGE;
        blk_b = ~hit_b;
        op_b  = hit_b ? stage_data[k*DATA_W +: DATA_W] : rf_b;
      end
    end
  end
  assign stall  = issue_valid & ~flush & (blk_a | blk_b);
  assign bubble = ~(issue_valid & ~stall & ~flush);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      w <= '0;
      m <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else begin
      v[0] <= ~bubble;
      w[0] <= wreg;
      m[0] <= rmem;
      d[0] <= dest;
      for (int k = 1; k < DEPTH; k++) begin
        v[k] <= v[k-1];
        w[k] <= w[k-1];
        m[k] <= m[k-1];
        d[k] <= d[k-1];
      end
    end
  end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
      if (flush && ~&flush_cnt) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench; an age-ordered instruction history model predicts every cycle.
module tb_hazard_ctrl;
  localparam int DATA_W = 32, REG_AW = 4, DEPTH = 3, LOAD_STAGE = 1;
  logic clk = 1'b0, rst = 1'b1;
  logic issue_valid = 1'b0, use_a = 1'b0, use_b = 1'b0, wreg = 1'b0, rmem = 1'b0, flush = 1'b0;
  logic [REG_AW-1:0] src_a = '0, src_b = '0, dest = '0;
  logic [DATA_W-1:0] rf_a = '0, rf_b = '0;
  logic [DEPTH*DATA_W-1:0] stage_data = '0;
  logic stall, hit_a, hit_b, bubble;
  logic [DATA_W-1:0] op_a, op_b;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src_a(src_a), .src_b(src_b),
    .use_a(use_a), .use_b(use_b), .dest(dest), .wreg(wreg), .rmem(rmem),
    .rf_a(rf_a), .rf_b(rf_b), .stage_data(stage_data), .flush(flush),
    .stall(stall), .op_a(op_a), .op_b(op_b), .hit_a(hit_a), .hit_b(hit_b), .bubble(bubble)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { bit v; bit [REG_AW-1:0] d; bit w; bit r; } ent_t;
  typedef struct {
    bit stall, bubble, hit_a, hit_b, def_a, def_b;
    bit [DATA_W-1:0] op_a, op_b;
    int scnt, fcnt;
  } exp_t;

  ent_t hist[$];
  exp_t exp_q[$];
  ent_t last_ins;
  bit last_rst = 1'b1, last_stall = 1'b0, last_flush = 1'b0;
  int m_scnt = 0, m_fcnt = 0;
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_hist();
    hist.delete();
    for (int k = 0; k < DEPTH; k++) hist.push_back('{v: 1'b0, d: '0, w: 1'b0, r: 1'b0});
  endtask

  // Youngest instruction writing src decides: ready -> forward its stage slot, not ready -> stall.
  task automatic resolve(input bit u, input bit [REG_AW-1:0] s, input bit [DATA_W-1:0] rf,
                         output bit hit, output bit blk, output bit [DATA_W-1:0] op);
    bit found = 1'b0;
    hit = 1'b0; blk = 1'b0; op = rf;
    for (int k = 0; k < DEPTH; k++)
      if (!found && u && hist[k].v && hist[k].w && hist[k].d == s) begin
        found = 1'b1;
        if (!hist[k].r || k >= LOAD_STAGE) begin
          hit = 1'b1;
          op = stage_data[k*DATA_W +: DATA_W];
        end else blk = 1'b1;
      end
  endtask

  task automatic step(input bit iv, input bit [REG_AW-1:0] sa, input bit [REG_AW-1:0] sb,
                      input bit ua, input bit ub, input bit [REG_AW-1:0] dst, input bit wr,
                      input bit rm, input bit fl, input bit rs, input logic [DEPTH*DATA_W-1:0] sd);
    exp_t e;
    bit ba, bb;
    @(posedge clk);
    if (!last_rst) begin
      hist.push_front(last_ins);
      void'(hist.pop_back());
      if (last_stall) m_scnt++;
      if (last_flush) m_fcnt++;
    end
    #1;
    issue_valid = iv; src_a = sa; src_b = sb; use_a = ua; use_b = ub; dest = dst;
    wreg = wr; rmem = rm; flush = fl; rst = rs; stage_data = sd;
    rf_a = $urandom; rf_b = $urandom;
    if (rs) begin
      clear_hist();
      m_scnt = 0;
      m_fcnt = 0;
    end
    resolve(ua, sa, rf_a, e.hit_a, ba, e.op_a);
    resolve(ub, sb, rf_b, e.hit_b, bb, e.op_b);
    e.def_a = !ba;
    e.def_b = !bb;
    e.stall = iv && !fl && (ba || bb);
    e.bubble = !(iv && !e.stall && !fl);
    e.scnt = m_scnt;
    e.fcnt = m_fcnt;
    exp_q.push_back(e);
    last_ins = '{v: !e.bubble, d: dst, w: wr, r: rm};
    last_rst = rs;
    last_stall = e.stall;
    last_flush = fl;
  endtask

  function automatic logic [DEPTH*DATA_W-1:0] rnd_sd();
    logic [DEPTH*DATA_W-1:0] s;
    for (int k = 0; k < DEPTH; k++) s[k*DATA_W +: DATA_W] = $urandom;
    return s;
  endfunction

  function automatic logic [DEPTH*DATA_W-1:0] sd3(input logic [DATA_W-1:0] s0, s1, s2);
    return {s2, s1, s0};
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", stall, e.stall);
        chk("bubble", bubble, e.bubble);
        if (e.def_a) begin
          chk("hit_a", hit_a, e.hit_a);
          chk("op_a", op_a, e.op_a);
        end
        if (e.def_b) begin
          chk("hit_b", hit_b, e.hit_b);
          chk("op_b", op_b, e.op_b);
        end
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", stall_cnt, e.scnt);
        chk("flush_cnt", flush_cnt, e.fcnt);
`endif
      end
    end
  end

  initial begin : driver
    int drain;
    clear_hist();
    last_ins = '{v: 1'b0, d: '0, w: 1'b0, r: 1'b0};
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, rnd_sd());
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, 1, rnd_sd());
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rnd_sd());
    // EX forwarding
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, rnd_sd());
    step(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, sd3(32'h55, 32'h1, 32'h2));
    // load-use: one stall, then forward from slot 1
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, rnd_sd());
    step(1, 0, 5, 0, 1, 6, 1, 0, 0, 0, rnd_sd());
    step(1, 0, 5, 0, 1, 6, 1, 0, 0, 0, sd3(32'h0, 32'hABCD, 32'h0));
    // youngest wins
    step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, rnd_sd());
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, rnd_sd());
    step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, rnd_sd());
    step(1, 2, 0, 1, 0, 8, 1, 0, 0, 0, sd3(32'h11, 32'h77, 32'h22));
    // flush over load-use
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, rnd_sd());
    step(1, 0, 5, 0, 1, 9, 1, 0, 1, 0, rnd_sd());
    step(1, 9, 9, 1, 1, 1, 0, 0, 0, 0, rnd_sd());
    // younger load shadows an older ready writer of the same register
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, rnd_sd());
    step(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, rnd_sd());
    step(1, 4, 0, 1, 0, 3, 1, 0, 0, 0, rnd_sd());
    step(1, 4, 0, 1, 0, 3, 1, 0, 0, 0, rnd_sd());
    // reset mid-stall, then empty scoreboard after release
    step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, rnd_sd());
    step(1, 6, 0, 1, 0, 1, 1, 0, 0, 0, rnd_sd());
    step(1, 6, 0, 1, 0, 1, 1, 0, 0, 1, rnd_sd());
    step(1, 6, 6, 1, 1, 1, 1, 0, 0, 0, rnd_sd());
    step(1, 6, 6, 1, 1, 1, 0, 0, 0, 0, rnd_sd());
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0, rnd_sd());
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
